// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and sizing for the HI/LO multiply/divide sequencer.
// Optional single-cycle multiply is enabled with HILO_FAST_MUL_EN.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int MDU_N = 32;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CNT_W = cnt_w(MDU_N);

endpackage

// File: rtl/hilo_mdu_ctrl_div_step.sv
// div_step: one combinational restoring-divide iteration.
// Shifts the next dividend bit into the remainder and trial-subtracts.
module div_step
    import hilo_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic [N:0]   rem_in,
    input  logic         in_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         qbit
);

    logic [N+1:0] part;
    logic [N+1:0] diff;

    assign part    = {rem_in, in_bit};
    assign diff    = part - {2'b00, divisor};
    assign qbit    = ~diff[N+1];
    assign rem_out = qbit ? diff[N:0] : part[N:0];

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO owner with iterative MULT/DIV and MTHI/MTLO writes.
// Define HILO_FAST_MUL_EN for single-cycle multiplies (divide stays iterative).
module hilo_mdu_ctrl
    import hilo_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         rd_req,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = (N == MDU_N) ? CNT_W : cnt_w(N);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [N:0]     rem;
    logic [N-1:0]   opd;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           done_q;
    logic [N-1:0]   hi_q;
    logic [N-1:0]   lo_q;

    mdu_op_t        opc;
    logic           op_mul;
    logic           op_div;
    logic           op_sgn;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           calc_go;

    always_comb begin
        opc    = mdu_op_t'(op);
        op_mul = (opc == OP_MULT) || (opc == OP_MULTU);
        op_div = (opc == OP_DIV) || (opc == OP_DIVU);
        op_sgn = (opc == OP_MULT) || (opc == OP_DIV);
        a_neg  = op_sgn & a[N-1];
        b_neg  = op_sgn & b[N-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

`ifdef HILO_FAST_MUL_EN
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;
    logic [2*N-1:0] fast_prod;

    // Low 2N bits of the extended product equal the signed/unsigned result.
    assign a_ext     = op_sgn ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    assign b_ext     = op_sgn ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    assign fast_prod = a_ext * b_ext;
    assign calc_go   = start & op_div;
`else
    assign calc_go   = start & (op_mul | op_div);
`endif

    logic [N:0]     madd;
    logic [2*N-1:0] mul_nx;

    // acc holds {partial product, remaining multiplier bits}.
    assign madd   = {1'b0, acc[2*N-1:N]}
                  + {1'b0, (acc[0] ? opd : {N{1'b0}})};
    assign mul_nx = {madd, acc[N-1:1]};

    logic [N:0] rem_nx;
    logic       qbit;

    div_step #(
        .N(N)
    ) u_div_step (
        .rem_in (rem),
        .in_bit (acc[N-1]),
        .divisor(opd),
        .rem_out(rem_nx),
        .qbit   (qbit)
    );

    logic [2*N-1:0] prod_fx;
    logic [N-1:0]   quo_fx;
    logic [N-1:0]   rem_fx;

    always_comb begin
        prod_fx = neg_q ? -acc : acc;
        quo_fx  = neg_q ? -acc[N-1:0] : acc[N-1:0];
        rem_fx  = neg_r ? -rem[N-1:0] : rem[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (calc_go) state_nx = CALC;
            CALC: if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && opc == OP_MTHI) hi_q <= a;
                    if (start && opc == OP_MTLO) lo_q <= a;
`ifdef HILO_FAST_MUL_EN
                    if (start && op_mul) begin
                        hi_q   <= fast_prod[2*N-1:N];
                        lo_q   <= fast_prod[N-1:0];
                        done_q <= 1'b1;
                    end
`endif
                    if (calc_go) begin
                        acc    <= {{N{1'b0}}, (op_div ? a_mag : b_mag)};
                        opd    <= op_div ? b_mag : a_mag;
                        rem    <= '0;
                        cnt    <= CW'(N);
                        is_div <= op_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        rem        <= rem_nx;
                        acc[N-1:0] <= {acc[N-2:0], qbit};
                    end else begin
                        acc <= mul_nx;
                    end
                end
                FIX: begin
                    hi_q   <= is_div ? rem_fx : prod_fx[2*N-1:N];
                    lo_q   <= is_div ? quo_fx : prod_fx[N-1:0];
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (rd_req | start);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: directed vectors for the HI/LO sequencer.
// Expected values are hand-computed; all checks go through chk().
module tb_hilo_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errs;
    int checks;

    hilo_mdu_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rd_req(rd_req),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo);
        int n;
        issue(o, x, y);
        wait_done(n);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_at;
        int n;
        logic [2:0] rop;
        errs   = 0;
        checks = 0;
        rst    = 1'b0;
        start  = 1'b1;
        op     = 3'd4;
        a      = 32'hDEADBEEF;
        b      = 32'h0;
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);

        issue(3'd4, 32'h11111111, 0);
        chk("mthi", hi, 32'h11111111);
        issue(3'd5, 32'h22222222, 0);
        chk("mtlo", lo, 32'h22222222);
        chk("mt_done", done, 0);

        issue(3'd6, 32'h33333333, 32'h5);
        chk("rsv_busy", busy, 0);
        chk("rsv_hi", hi, 32'h11111111);
        chk("rsv_lo", lo, 32'h22222222);

        // DIVU 100/7 with read and MTLO requests while busy
        issue(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("stall_rd", stall, 1);
        chk("calc_hi", hi, 32'h11111111);
        chk("calc_lo", lo, 32'h22222222);
        @(negedge clk);
        rd_req = 1'b0;
        start  = 1'b1;
        op     = 3'd5;
        a      = 32'h00000BAD;
        #1;
        chk("stall_mt", stall, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("stall_idle_req", stall, 0);
        chk("busy_calc", busy, 1);
        wait_done(n);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        issue(3'd5, 32'hA5A5A5A5, 0);
        chk("mtlo_a5", lo, 32'hA5A5A5A5);

`ifndef HILO_FAST_MUL_EN
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
            end
            @(negedge clk);
        end
        chk("multu_busy", busy_n, 33);
        chk("multu_done_n", done_n, 1);
        chk("multu_done_at", done_at, 33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        run("mult", 3'd0, 32'd3, 32'hFFFFFFFC, 33,
            32'hFFFFFFFF, 32'hFFFFFFF4);
        rop = 3'd0;
`else
        issue(3'd0, 32'd3, 32'hFFFFFFFC);
        chk("fmult_done", done, 1);
        chk("fmult_busy", busy, 0);
        chk("fmult_hi", hi, 32'hFFFFFFFF);
        chk("fmult_lo", lo, 32'hFFFFFFF4);
        run("fmultu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
            32'hFFFFFFFE, 32'h00000001);
        rop = 3'd3;
`endif

        run("div_m7", 3'd2, 32'hFFFFFFF9, 32'd2, 33,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33,
            32'h0, 32'h80000000);
        run("divu_z", 3'd3, 32'h1234, 32'h0, 33,
            32'h1234, 32'hFFFFFFFF);
        run("div_z", 3'd2, 32'hFFFFFFF9, 32'h0, 33,
            32'hFFFFFFF9, 32'h00000001);

        // reset abandons an in-flight operation at CALC cycle 10
        issue(rop, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_hi", hi, 0);
        chk("mid_lo", lo, 0);
        chk("mid_done", done, 0);
        rst    = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        chk("mid_no_done", done_n, 0);
        chk("mid_hi_after", hi, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
